// File: rtl/chesslab_pkg.sv
// Shared definitions for the chess-lab game datapath.
// Holds the FSM state encodings of the move checker, the result codes it
// records, the board coordinate width and bounds, and the "valid square"
// predicate (also usable by the move generator).
package chesslab_pkg;

  localparam int COORD_W = 4;

  localparam logic [COORD_W-1:0] COORD_MIN = 4'd1;
  localparam logic [COORD_W-1:0] COORD_MAX = 4'd8;

  // Checker FSM states; the encoding is also exported on db_estado.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PEDE      = 3'd1;
  localparam logic [2:0] ST_CAPTURA   = 3'd2;
  localparam logic [2:0] ST_AGUARDA   = 3'd3;
  localparam logic [2:0] ST_RESULTADO = 3'd4;
  localparam logic [2:0] ST_FIM       = 3'd5;

  // Outcome of a round, recorded when AGUARDA is left.
  localparam logic [1:0] RES_NENHUM  = 2'd0;
  localparam logic [1:0] RES_ACERTO  = 2'd1;
  localparam logic [1:0] RES_ERRO    = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  // True when both coordinates lie on the 8x8 board (1..8).
  function automatic logic casa_valida(input logic [COORD_W-1:0] col,
                                       input logic [COORD_W-1:0] lin);
    return (col >= COORD_MIN) && (col <= COORD_MAX) &&
           (lin >= COORD_MIN) && (lin <= COORD_MAX);
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Answer-window timer for the move checker.
// Ports:
//   clock, reset     : clock and asynchronous active-high reset
//   carrega          : clear the count to zero (has priority over conta)
//   conta            : advance the count by one
//   fim_contagem     : high while the count equals TIMEOUT_CICLOS-1
// The count holds at the terminal value instead of wrapping, so the width
// only needs to cover 0..TIMEOUT_CICLOS-1.
module contador_timeout #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic clock,
  input  logic reset,
  input  logic carrega,
  input  logic conta,
  output logic fim_contagem
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carrega)
      cnt_d = '0;
    else if (conta && (cnt_q != CNT_FIM))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign fim_contagem = (cnt_q == CNT_FIM);

endmodule

// File: rtl/verificador_jogada.sv
// Move checker: per round requests a target square from the move generator,
// latches it, waits up to TIMEOUT_CICLOS cycles for the player's square and
// classifies the round as hit, miss or timeout. Keeps a saturating hit count
// and ends the game after RODADAS rounds.
// Ports:
//   clock, reset              : clock, asynchronous active-high reset
//   iniciar                   : start / next-round request (level)
//   coluna_alvo, linha_alvo   : target square from the generator
//   jogada_valida             : one-cycle strobe, player square present
//   coluna_jog, linha_jog     : player square, valid with the strobe
//   novaJogada                : one-cycle request to the generator
//   acerto, erro, timeout     : one-cycle round outcome pulses
//   pronto, fim_jogo          : in IDLE / in FIM
//   pontos, rodada            : hit count / rounds completed
//   db_estado                 : FSM state for debug
module verificador_jogada
  import chesslab_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int RODADAS        = 8,
  parameter int PONTOS_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [COORD_W-1:0]  coluna_alvo,
  input  logic [COORD_W-1:0]  linha_alvo,
  input  logic                jogada_valida,
  input  logic [COORD_W-1:0]  coluna_jog,
  input  logic [COORD_W-1:0]  linha_jog,
  output logic                novaJogada,
  output logic                acerto,
  output logic                erro,
  output logic                timeout,
  output logic                pronto,
  output logic                fim_jogo,
  output logic [PONTOS_W-1:0] pontos,
  output logic [3:0]          rodada,
  output logic [2:0]          db_estado
);

  localparam logic [3:0] RODADAS_FIM = 4'(RODADAS);

  logic [2:0]          estado_q, estado_d;
  logic [1:0]          res_q, res_d;
  logic [PONTOS_W-1:0] pontos_q, pontos_d;
  logic [3:0]          rodada_q, rodada_d;
  logic [COORD_W-1:0]  col_alvo_q, col_alvo_d;
  logic [COORD_W-1:0]  lin_alvo_q, lin_alvo_d;
  logic                timer_fim;
  logic                bateu;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .carrega     (estado_q == ST_CAPTURA),
    .conta       (estado_q == ST_AGUARDA),
    .fim_contagem(timer_fim)
  );

  // Equality alone is not a hit: a generator fault producing an off-board
  // target must not reward an equally off-board answer.
  assign bateu = (coluna_jog == col_alvo_q) && (linha_jog == lin_alvo_q) &&
                 casa_valida(coluna_jog, linha_jog);

  always_comb begin
    estado_d   = estado_q;
    res_d      = res_q;
    pontos_d   = pontos_q;
    rodada_d   = rodada_q;
    col_alvo_d = col_alvo_q;
    lin_alvo_d = lin_alvo_q;
    case (estado_q)
      ST_IDLE: begin
        if (iniciar) begin
          estado_d = ST_PEDE;
          if (rodada_q == 4'd0) pontos_d = '0;
        end
      end
      ST_PEDE: estado_d = ST_CAPTURA;
      ST_CAPTURA: begin
        col_alvo_d = coluna_alvo;
        lin_alvo_d = linha_alvo;
        estado_d   = ST_AGUARDA;
      end
      ST_AGUARDA: begin
        // A strobe on the last window cycle beats the timeout.
        if (jogada_valida) begin
          res_d    = bateu ? RES_ACERTO : RES_ERRO;
          estado_d = ST_RESULTADO;
        end else if (timer_fim) begin
          res_d    = RES_TIMEOUT;
          estado_d = ST_RESULTADO;
        end
      end
      ST_RESULTADO: begin
        if ((res_q == RES_ACERTO) && !(&pontos_q))
          pontos_d = pontos_q + 1'b1;
        rodada_d = rodada_q + 4'd1;
        estado_d = (rodada_d == RODADAS_FIM) ? ST_FIM : ST_IDLE;
      end
      ST_FIM: begin
        if (iniciar) begin
          rodada_d = 4'd0;
          pontos_d = '0;
          estado_d = ST_PEDE;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ST_IDLE;
      res_q      <= RES_NENHUM;
      pontos_q   <= '0;
      rodada_q   <= 4'd0;
      col_alvo_q <= '0;
      lin_alvo_q <= '0;
    end else begin
      estado_q   <= estado_d;
      res_q      <= res_d;
      pontos_q   <= pontos_d;
      rodada_q   <= rodada_d;
      col_alvo_q <= col_alvo_d;
      lin_alvo_q <= lin_alvo_d;
    end
  end

  // Outputs decode the state register; the pulse lines qualify the
  // recorded outcome with RESULTADO so each lasts exactly one cycle.
  assign novaJogada = (estado_q == ST_PEDE);
  assign acerto     = (estado_q == ST_RESULTADO) && (res_q == RES_ACERTO);
  assign erro       = (estado_q == ST_RESULTADO) && (res_q == RES_ERRO);
  assign timeout    = (estado_q == ST_RESULTADO) && (res_q == RES_TIMEOUT);
  assign pronto     = (estado_q == ST_IDLE);
  assign fim_jogo   = (estado_q == ST_FIM);
  assign pontos     = pontos_q;
  assign rodada     = rodada_q;
  assign db_estado  = estado_q;

endmodule
